// File: rtl/dtcm_arbiter_pkg.sv
// Shared widths, requester IDs and the winner-selection helper for the DTCM arbiter.
package dtcm_arbiter_pkg;

   localparam int XLEN        = 32;
   localparam int DTCM_RAM_AW = 14;

   localparam logic DTCM_ARB_ID_LSU = 1'b0;
   localparam logic DTCM_ARB_ID_EXT = 1'b1;

   typedef struct packed {
      logic                   read;
      logic [DTCM_RAM_AW-1:0] addr;
      logic [XLEN-1:0]        wdata;
      logic [XLEN/8-1:0]      wmask;
   } dtcm_cmd_t;

   // pref is the ID that wins a tie in round-robin mode.
   function automatic logic pick_winner(input logic lsu_v, input logic ext_v,
                                        input logic pref, input logic lsu_prio);
      if (lsu_v && ext_v) return lsu_prio ? DTCM_ARB_ID_LSU : pref;
      return ext_v ? DTCM_ARB_ID_EXT : DTCM_ARB_ID_LSU;
   endfunction

endpackage

// File: rtl/dtcm_arbiter_id_fifo.sv
// Outstanding-command owner FIFO: 1-bit requester IDs, registered full/empty flags.
module arb_id_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= din_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/dtcm_arbiter.sv
// Shares the DTCM port between the LSU and the external bus; commands are muxed
// combinationally, responses are returned in issue order using the owner FIFO.
module dtcm_arbiter
   import dtcm_arbiter_pkg::*;
#(
   parameter int OUTS_DEPTH = 2,
   parameter bit LSU_PRIO   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   lsu_cmd_valid,
   output logic                   lsu_cmd_ready,
   input  logic                   lsu_cmd_read,
   input  logic [DTCM_RAM_AW-1:0] lsu_cmd_addr,
   input  logic [XLEN-1:0]        lsu_cmd_wdata,
   input  logic [XLEN/8-1:0]      lsu_cmd_wmask,
   output logic                   lsu_rsp_valid,
   input  logic                   lsu_rsp_ready,
   output logic [XLEN-1:0]        lsu_rsp_rdata,
   input  logic                   ext_cmd_valid,
   output logic                   ext_cmd_ready,
   input  logic                   ext_cmd_read,
   input  logic [DTCM_RAM_AW-1:0] ext_cmd_addr,
   input  logic [XLEN-1:0]        ext_cmd_wdata,
   input  logic [XLEN/8-1:0]      ext_cmd_wmask,
   output logic                   ext_rsp_valid,
   input  logic                   ext_rsp_ready,
   output logic [XLEN-1:0]        ext_rsp_rdata,
   output logic                   dtcm_cmd_valid,
   input  logic                   dtcm_cmd_ready,
   output logic                   dtcm_cmd_read,
   output logic [DTCM_RAM_AW-1:0] dtcm_cmd_addr,
   output logic [XLEN-1:0]        dtcm_cmd_wdata,
   output logic [XLEN/8-1:0]      dtcm_cmd_wmask,
   input  logic                   dtcm_rsp_valid,
   output logic                   dtcm_rsp_ready,
   input  logic [XLEN-1:0]        dtcm_rsp_rdata
);

   logic      fifo_full, fifo_empty, fifo_head, fifo_pop;
   logic      lock_q, lock_d;
   logic      lock_id_q, lock_id_d;
   logic      pref_q, pref_d;
   logic      win_id, lsu_win, ext_win, cmd_hs, rsp_live;
   dtcm_cmd_t cmd_sel;

   // A lock only holds while its requester still asserts valid, so the muxed
   // payload always belongs to a requester that is actually requesting.
   always_comb begin
      win_id = pick_winner(lsu_cmd_valid, ext_cmd_valid, pref_q, LSU_PRIO);
      if (lock_q && ((lock_id_q == DTCM_ARB_ID_EXT) ? ext_cmd_valid : lsu_cmd_valid))
         win_id = lock_id_q;
   end

   assign dtcm_cmd_valid = rst_n & (lsu_cmd_valid | ext_cmd_valid) & ~fifo_full;
   assign lsu_win        = dtcm_cmd_valid & (win_id == DTCM_ARB_ID_LSU);
   assign ext_win        = dtcm_cmd_valid & (win_id == DTCM_ARB_ID_EXT);
   assign lsu_cmd_ready  = lsu_win & dtcm_cmd_ready;
   assign ext_cmd_ready  = ext_win & dtcm_cmd_ready;
   assign cmd_hs         = dtcm_cmd_valid & dtcm_cmd_ready;

   always_comb begin
      cmd_sel = '0;
      if (ext_win)      cmd_sel = '{ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask};
      else if (lsu_win) cmd_sel = '{lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask};
   end

   assign dtcm_cmd_read  = cmd_sel.read;
   assign dtcm_cmd_addr  = cmd_sel.addr;
   assign dtcm_cmd_wdata = cmd_sel.wdata;
   assign dtcm_cmd_wmask = cmd_sel.wmask;

   always_comb begin
      lock_d    = dtcm_cmd_valid & ~dtcm_cmd_ready;
      lock_id_d = win_id;
      pref_d    = cmd_hs ? ~win_id : pref_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         lock_id_q <= DTCM_ARB_ID_LSU;
         pref_q    <= DTCM_ARB_ID_LSU;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         pref_q    <= pref_d;
      end
   end

   // A response with nothing outstanding is swallowed so the RAM cannot stall.
   assign rsp_live       = rst_n & dtcm_rsp_valid & ~fifo_empty;
   assign lsu_rsp_valid  = rsp_live & (fifo_head == DTCM_ARB_ID_LSU);
   assign ext_rsp_valid  = rsp_live & (fifo_head == DTCM_ARB_ID_EXT);
   assign lsu_rsp_rdata  = lsu_rsp_valid ? dtcm_rsp_rdata : '0;
   assign ext_rsp_rdata  = ext_rsp_valid ? dtcm_rsp_rdata : '0;
   assign dtcm_rsp_ready = rst_n & (fifo_empty ? dtcm_rsp_valid :
                           ((fifo_head == DTCM_ARB_ID_EXT) ? ext_rsp_ready : lsu_rsp_ready));
   assign fifo_pop       = rsp_live & dtcm_rsp_ready;

   arb_id_fifo #(.DEPTH(OUTS_DEPTH)) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_hs),
      .din_i   (win_id),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter: a round-robin instance and a fixed-LSU-priority instance.
module tb_dtcm_arbiter;
   import dtcm_arbiter_pkg::*;

   logic clk, rst_n;
   logic lsu_cmd_valid, lsu_cmd_read, lsu_rsp_ready;
   logic [DTCM_RAM_AW-1:0] lsu_cmd_addr;
   logic [XLEN-1:0] lsu_cmd_wdata;
   logic [XLEN/8-1:0] lsu_cmd_wmask;
   logic ext_cmd_valid, ext_cmd_read, ext_rsp_ready;
   logic [DTCM_RAM_AW-1:0] ext_cmd_addr;
   logic [XLEN-1:0] ext_cmd_wdata;
   logic [XLEN/8-1:0] ext_cmd_wmask;
   logic dtcm_cmd_ready, dtcm_rsp_valid;
   logic [XLEN-1:0] dtcm_rsp_rdata;

   logic lsu_cmd_ready, lsu_rsp_valid, ext_cmd_ready, ext_rsp_valid;
   logic [XLEN-1:0] lsu_rsp_rdata, ext_rsp_rdata;
   logic dtcm_cmd_valid, dtcm_cmd_read, dtcm_rsp_ready;
   logic [DTCM_RAM_AW-1:0] dtcm_cmd_addr;
   logic [XLEN-1:0] dtcm_cmd_wdata;
   logic [XLEN/8-1:0] dtcm_cmd_wmask;

   logic p_lsu_cmd_ready, p_lsu_rsp_valid, p_ext_cmd_ready, p_ext_rsp_valid;
   logic [XLEN-1:0] p_lsu_rsp_rdata, p_ext_rsp_rdata;
   logic p_dtcm_cmd_valid, p_dtcm_cmd_read, p_dtcm_rsp_ready;
   logic [DTCM_RAM_AW-1:0] p_dtcm_cmd_addr;
   logic [XLEN-1:0] p_dtcm_cmd_wdata;
   logic [XLEN/8-1:0] p_dtcm_cmd_wmask;

   int n_checks = 0;
   int n_errors = 0;

   dtcm_arbiter #(.OUTS_DEPTH(2), .LSU_PRIO(1'b0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
      .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
      .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
      .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
      .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
      .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
      .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata)
   );

   dtcm_arbiter #(.OUTS_DEPTH(2), .LSU_PRIO(1'b1)) u_pr (
      .clk(clk), .rst_n(rst_n),
      .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(p_lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
      .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
      .lsu_rsp_valid(p_lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(p_lsu_rsp_rdata),
      .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(p_ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
      .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
      .ext_rsp_valid(p_ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(p_ext_rsp_rdata),
      .dtcm_cmd_valid(p_dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(p_dtcm_cmd_read),
      .dtcm_cmd_addr(p_dtcm_cmd_addr), .dtcm_cmd_wdata(p_dtcm_cmd_wdata), .dtcm_cmd_wmask(p_dtcm_cmd_wmask),
      .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(p_dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      lsu_cmd_valid = 0; lsu_cmd_read = 0; lsu_cmd_addr = '0; lsu_cmd_wdata = '0; lsu_cmd_wmask = '0;
      ext_cmd_valid = 0; ext_cmd_read = 0; ext_cmd_addr = '0; ext_cmd_wdata = '0; ext_cmd_wmask = '0;
      lsu_rsp_ready = 0; ext_rsp_ready = 0;
      dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      cyc();
      cyc();
      rst_n = 1;
   endtask

   // Once the RAM sees a command stalled, the same command must be presented next cycle.
   logic stall_prev = 1'b0;
   logic [DTCM_RAM_AW-1:0] addr_prev = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", dtcm_cmd_valid, 1);
            check("hold_addr", dtcm_cmd_addr, addr_prev);
         end
         stall_prev = dtcm_cmd_valid & ~dtcm_cmd_ready;
         addr_prev  = dtcm_cmd_addr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      logic exp_ext;
      int   owner;

      // reset state, even with requests present
      rst_n = 0;
      clear_inputs();
      lsu_cmd_valid = 1; lsu_cmd_addr = 14'h0010; dtcm_cmd_ready = 1; dtcm_rsp_valid = 1;
      #3;
      check("rst_cmd_valid", dtcm_cmd_valid, 0);
      check("rst_lsu_ready", lsu_cmd_ready, 0);
      check("rst_rsp_ready", dtcm_rsp_ready, 0);
      check("rst_lsu_rsp_v", lsu_rsp_valid, 0);
      check("rst_cmd_addr", dtcm_cmd_addr, 0);
      check("rst_fifo_empty", u_rr.fifo_empty, 1);

      // single LSU read
      do_reset();
      lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 14'h0010; dtcm_cmd_ready = 1;
      lsu_rsp_ready = 1; ext_rsp_ready = 1;
      #1;
      check("t1_cmd_valid", dtcm_cmd_valid, 1);
      check("t1_cmd_addr", dtcm_cmd_addr, 32'h10);
      check("t1_cmd_read", dtcm_cmd_read, 1);
      check("t1_lsu_ready", lsu_cmd_ready, 1);
      check("t1_ext_ready", ext_cmd_ready, 0);
      cyc();
      lsu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hDEADBEEF;
      #1;
      check("t1_lsu_rsp_v", lsu_rsp_valid, 1);
      check("t1_lsu_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
      check("t1_ext_rsp_v", ext_rsp_valid, 0);
      check("t1_rsp_ready", dtcm_rsp_ready, 1);
      cyc();
      dtcm_rsp_valid = 0;
      #1;
      check("t1_fifo_empty", u_rr.fifo_empty, 1);

      // round-robin alternation with a response every cycle
      do_reset();
      lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 14'h0100;
      ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = 14'h0200;
      dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
      for (int k = 0; k < 5; k++) begin
         dtcm_rsp_valid = (k > 0);
         dtcm_rsp_rdata = 32'hA0 + k;
         if (k == 4) begin lsu_cmd_valid = 0; ext_cmd_valid = 0; end
         #1;
         if (k < 4) begin
            exp_ext = k[0];
            check("rr_lsu_ready", lsu_cmd_ready, !exp_ext);
            check("rr_ext_ready", ext_cmd_ready, exp_ext);
            check("rr_addr", dtcm_cmd_addr, exp_ext ? 32'h200 : 32'h100);
         end
         if (k > 0) begin
            owner = (k - 1) % 2;
            check("rr_lsu_rsp_v", lsu_rsp_valid, owner == 0);
            check("rr_ext_rsp_v", ext_rsp_valid, owner == 1);
            check("rr_rdata", (owner == 0) ? lsu_rsp_rdata : ext_rsp_rdata, 32'hA0 + k);
         end
         cyc();
      end
      dtcm_rsp_valid = 0;
      #1;
      check("rr_fifo_empty", u_rr.fifo_empty, 1);

      // fixed LSU priority
      do_reset();
      lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 14'h0100;
      ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = 14'h0200;
      dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
      for (int k = 0; k < 5; k++) begin
         dtcm_rsp_valid = (k > 0);
         if (k == 3) lsu_cmd_valid = 0;
         if (k == 4) ext_cmd_valid = 0;
         #1;
         if (k < 3) begin
            check("pr_lsu_ready", p_lsu_cmd_ready, 1);
            check("pr_ext_ready", p_ext_cmd_ready, 0);
         end else if (k == 3) begin
            check("pr_ext_ready_late", p_ext_cmd_ready, 1);
            check("pr_ext_addr", p_dtcm_cmd_addr, 32'h200);
         end
         cyc();
      end
      dtcm_rsp_valid = 0;
      #1;
      check("pr_fifo_empty", u_pr.fifo_empty, 1);

      // grant lock while the RAM stalls an ext write
      do_reset();
      ext_cmd_valid = 1; ext_cmd_read = 0; ext_cmd_addr = 14'h0300;
      ext_cmd_wdata = 32'h12345678; ext_cmd_wmask = 4'b0110;
      lsu_rsp_ready = 1; ext_rsp_ready = 1;
      #1;
      check("lk_valid", dtcm_cmd_valid, 1);
      check("lk_read", dtcm_cmd_read, 0);
      check("lk_wdata", dtcm_cmd_wdata, 32'h12345678);
      check("lk_wmask", dtcm_cmd_wmask, 4'b0110);
      check("lk_ext_ready0", ext_cmd_ready, 0);
      cyc();
      lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 14'h0100;
      #1;
      check("lk_addr_c1", dtcm_cmd_addr, 32'h300);
      check("lk_lsu_ready_c1", lsu_cmd_ready, 0);
      cyc();
      #1;
      check("lk_addr_c2", dtcm_cmd_addr, 32'h300);
      cyc();
      dtcm_cmd_ready = 1;
      #1;
      check("lk_ext_hs", ext_cmd_ready, 1);
      check("lk_lsu_hs", lsu_cmd_ready, 0);
      cyc();
      ext_cmd_valid = 0;
      #1;
      check("lk_lsu_next", lsu_cmd_ready, 1);
      check("lk_lsu_addr", dtcm_cmd_addr, 32'h100);
      cyc();
      lsu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h55;
      #1;
      check("lk_rsp1_ext", ext_rsp_valid, 1);
      check("lk_rsp1_lsu", lsu_rsp_valid, 0);
      cyc();
      dtcm_rsp_rdata = 32'h66;
      #1;
      check("lk_rsp2_lsu", lsu_rsp_valid, 1);
      check("lk_rsp2_rdata", lsu_rsp_rdata, 32'h66);
      cyc();
      dtcm_rsp_valid = 0;

      // outstanding limit, registered full
      do_reset();
      dtcm_cmd_ready = 1;
      lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 14'h0010;
      #1;
      check("fl_ready_1", lsu_cmd_ready, 1);
      cyc();
      lsu_cmd_addr = 14'h0014;
      #1;
      check("fl_ready_2", lsu_cmd_ready, 1);
      cyc();
      lsu_cmd_addr = 14'h0018;
      #1;
      check("fl_ready_3", lsu_cmd_ready, 0);
      check("fl_valid_3", dtcm_cmd_valid, 0);
      cyc();
      dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h11; lsu_rsp_ready = 1;
      #1;
      check("fl_no_bypass", lsu_cmd_ready, 0);
      check("fl_rsp_v", lsu_rsp_valid, 1);
      check("fl_rsp_data", lsu_rsp_rdata, 32'h11);
      cyc();
      dtcm_rsp_valid = 0;
      #1;
      check("fl_ready_after_pop", lsu_cmd_ready, 1);
      check("fl_addr_after_pop", dtcm_cmd_addr, 32'h18);
      cyc();

      // response backpressure, then async reset mid-stream
      lsu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h22; lsu_rsp_ready = 0;
      #1;
      check("bp_rsp_ready_a", dtcm_rsp_ready, 0);
      check("bp_rsp_v", lsu_rsp_valid, 1);
      cyc();
      #1;
      check("bp_rsp_ready_b", dtcm_rsp_ready, 0);
      check("bp_no_pop", u_rr.fifo_full, 1);
      cyc();
      lsu_rsp_ready = 1;
      #1;
      check("bp_rsp_ready_c", dtcm_rsp_ready, 1);
      check("bp_rdata", lsu_rsp_rdata, 32'h22);
      cyc();
      lsu_cmd_valid = 1; lsu_cmd_addr = 14'h0020; dtcm_rsp_rdata = 32'h33;
      #1;
      check("ar_pre_valid", dtcm_cmd_valid, 1);
      check("ar_pre_empty", u_rr.fifo_empty, 0);
      rst_n = 0;
      #1;
      check("ar_cmd_valid", dtcm_cmd_valid, 0);
      check("ar_lsu_ready", lsu_cmd_ready, 0);
      check("ar_rsp_valid", lsu_rsp_valid, 0);
      check("ar_rsp_ready", dtcm_rsp_ready, 0);
      check("ar_fifo_empty", u_rr.fifo_empty, 1);
      clear_inputs();
      cyc();
      rst_n = 1;

      // stray response with nothing outstanding is dropped
      dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h77; lsu_rsp_ready = 0; ext_rsp_ready = 0;
      #1;
      check("dr_rsp_ready", dtcm_rsp_ready, 1);
      check("dr_lsu_rsp_v", lsu_rsp_valid, 0);
      check("dr_ext_rsp_v", ext_rsp_valid, 0);
      cyc();
      dtcm_rsp_valid = 0;
      #1;
      check("dr_fifo_empty", u_rr.fifo_empty, 1);
      cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
